// File: rtl/tt_um_hoene_smart_led_pkg.sv
// Shared definitions for the smart-LED daisy-chain frame selector:
// state and error encodings plus the word-count clamp used at claim time.
package tt_um_hoene_smart_led_pkg;

  localparam int DEFAULT_WORD_BITS = 32;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_MARKER  = 2'd1,
    ERR_OVERRUN = 2'd2,
    ERR_PARITY  = 2'd3
  } err_e;

  // A request of zero still claims one word; anything too large saturates.
  function automatic int unsigned clamp_words(input int unsigned n,
                                              input int unsigned max_w);
    if (n == 0) return 1;
    if (n > max_w) return max_w;
    return n;
  endfunction

endpackage

// File: rtl/tt_um_hoene_word_capture.sv
// Bit counter, word index and shift buffer for the frame selector.
// Flags the strobe that carries the last bit of the last claimed word.
module tt_um_hoene_word_capture #(
  parameter int WORD_BITS = 32,
  parameter int MAX_WORDS = 4,
  parameter int CNT_W     = $clog2(WORD_BITS),
  parameter int IDX_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           strobe,
  input  logic                           shift_en,
  input  logic                           claim,
  input  logic                           in_data,
  input  logic [IDX_W-1:0]               nw,
  output logic [CNT_W-1:0]               bit_counter,
  output logic [WORD_BITS*MAX_WORDS-1:0] shift_next,
  output logic                           last_bit
);

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WORD_BITS - 1);

  logic [CNT_W-1:0]               bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]               word_idx_q, word_idx_d;
  logic [IDX_W-1:0]               slot;
  logic [WORD_BITS*MAX_WORDS-1:0] shift_q;
  logic                           at_last_pos;
  logic                           at_last_word;

  assign bit_counter = bit_cnt_q;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    word_idx_d   = word_idx_q;
    shift_next   = shift_q;
    at_last_pos  = (bit_cnt_q == LAST_POS);
    at_last_word = (word_idx_q == nw - 1'b1);
    slot         = claim ? '0 : word_idx_q;

    if (strobe) bit_cnt_d = at_last_pos ? '0 : bit_cnt_q + 1'b1;

    if (shift_en) begin
      for (int k = 0; k < MAX_WORDS; k++) begin
        if (slot == IDX_W'(k))
          shift_next[k*WORD_BITS +: WORD_BITS] =
            {shift_q[k*WORD_BITS +: WORD_BITS-1], in_data};
      end
    end

    // The claim strobe is always bit 0, so it can never be a word's last bit.
    last_bit = shift_en && !claim && at_last_pos && at_last_word;

    if (claim)
      word_idx_d = '0;
    else if (shift_en && at_last_pos && !at_last_word)
      word_idx_d = word_idx_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
      shift_q    <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      word_idx_q <= word_idx_d;
      shift_q    <= shift_next;
    end
  end

endmodule

// File: rtl/tt_um_hoene_protocol_select_multi.sv
// Frame selector: claims up to MAX_WORDS consecutive unclaimed LED words,
// double-buffers them for the PWM stage and reports the first error per frame.
module tt_um_hoene_protocol_select_multi
  import tt_um_hoene_smart_led_pkg::*;
#(
  parameter int WORD_BITS = DEFAULT_WORD_BITS,
  parameter int MAX_WORDS = 4,
  parameter int CNT_W     = $clog2(WORD_BITS),
  parameter int IDX_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_data,
  input  logic                           in_clk,
  input  logic                           in_sync,
  input  logic                           parity_error,
  input  logic [IDX_W-1:0]               num_words,
  output logic [CNT_W-1:0]               bit_counter,
  output logic                           swap_forward_bit,
  output logic                           pwm_set,
  output logic [WORD_BITS*MAX_WORDS-1:0] led_data,
  output logic [IDX_W-1:0]               led_words,
  output logic                           error,
  output logic [1:0]                     error_code,
  output logic [1:0]                     state
);

  state_e                         state_q, state_d;
  err_e                           code_q, code_d;
  logic                           swap_q, swap_d;
  logic                           pwm_q, pwm_d;
  logic                           error_q, error_d;
  logic [WORD_BITS*MAX_WORDS-1:0] led_data_q, led_data_d;
  logic [IDX_W-1:0]               led_words_q, led_words_d;
  logic [IDX_W-1:0]               nw_q, nw_d;

  logic                           valid_bit, at_marker, claim, shift_en, last_bit;
  logic [WORD_BITS*MAX_WORDS-1:0] shift_next;

  assign valid_bit = in_clk && !parity_error && in_sync;
  assign at_marker = (bit_counter == '0);
  assign claim     = valid_bit && (state_q == SEARCH) && at_marker && in_data;
  assign shift_en  = claim || (valid_bit && (state_q == CAPTURE));

  tt_um_hoene_word_capture #(
    .WORD_BITS (WORD_BITS),
    .MAX_WORDS (MAX_WORDS),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) u_capture (
    .clk         (clk),
    .rst         (rst),
    .clear       (!in_sync),
    .strobe      (in_clk),
    .shift_en    (shift_en),
    .claim       (claim),
    .in_data     (in_data),
    .nw          (nw_q),
    .bit_counter (bit_counter),
    .shift_next  (shift_next),
    .last_bit    (last_bit)
  );

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    swap_d      = swap_q;
    pwm_d       = 1'b0;
    error_d     = error_q;
    led_data_d  = led_data_q;
    led_words_d = led_words_q;
    nw_d        = nw_q;

    if (!in_sync) begin
      state_d = SEARCH;
      swap_d  = 1'b0;
      error_d = 1'b0;
      code_d  = ERR_NONE;
    end else if (in_clk) begin
      swap_d = 1'b0;
      if (parity_error) begin
        if (state_q == CAPTURE) begin
          state_d = DONE;
          error_d = 1'b1;
          if (!error_q) code_d = ERR_PARITY;
        end
      end else begin
        unique case (state_q)
          SEARCH: if (claim) begin
            swap_d  = 1'b1;
            state_d = CAPTURE;
            nw_d    = IDX_W'(clamp_words(int'(num_words), MAX_WORDS));
          end
          CAPTURE: begin
            if (at_marker) begin
              swap_d = 1'b1;
              if (!in_data) begin
                error_d = 1'b1;
                if (!error_q) code_d = ERR_MARKER;
              end
            end
            if (last_bit) begin
              for (int k = 0; k < MAX_WORDS; k++)
                led_data_d[k*WORD_BITS +: WORD_BITS] = (k < int'(nw_q)) ?
                  shift_next[k*WORD_BITS +: WORD_BITS] : '0;
              led_words_d = nw_q;
              pwm_d       = 1'b1;
              state_d     = DONE;
            end
          end
          DONE: if (at_marker && in_data) begin
            error_d = 1'b1;
            if (!error_q) code_d = ERR_OVERRUN;
          end
          default: state_d = SEARCH;
        endcase
      end
    end
  end

  // NOTE: the LED buffer is reset explicitly; it is a plain register, not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      code_q      <= ERR_NONE;
      swap_q      <= 1'b0;
      pwm_q       <= 1'b0;
      error_q     <= 1'b0;
      led_data_q  <= '0;
      led_words_q <= '0;
      nw_q        <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      swap_q      <= swap_d;
      pwm_q       <= pwm_d;
      error_q     <= error_d;
      led_data_q  <= led_data_d;
      led_words_q <= led_words_d;
      nw_q        <= nw_d;
    end
  end

  assign swap_forward_bit = swap_q;
  assign pwm_set          = pwm_q;
  assign led_data         = led_data_q;
  assign led_words        = led_words_q;
  assign error            = error_q;
  assign error_code       = code_q;
  assign state            = state_q;

endmodule

// File: tb/tb_tt_um_hoene_protocol_select_multi.sv
// Directed bench for the multi-word frame selector with WORD_BITS=8, MAX_WORDS=4.
module tb_tt_um_hoene_protocol_select_multi;

  localparam int WB = 8;
  localparam int MW = 4;
  localparam int CW = 3;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_data, in_clk, in_sync, parity_error;
  logic [IW-1:0] num_words;
  logic [CW-1:0] bit_counter;
  logic          swap_forward_bit, pwm_set;
  logic [WB*MW-1:0] led_data;
  logic [IW-1:0] led_words;
  logic          error;
  logic [1:0]    error_code;
  logic [1:0]    state;

  int checks = 0;
  int fails  = 0;

  logic [7:0] swap_mask, pwm_mask;
  logic       last_swap, last_pwm;

  tt_um_hoene_protocol_select_multi #(
    .WORD_BITS (WB), .MAX_WORDS (MW), .CNT_W (CW), .IDX_W (IW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_data          (in_data),
    .in_clk           (in_clk),
    .in_sync          (in_sync),
    .parity_error     (parity_error),
    .num_words        (num_words),
    .bit_counter      (bit_counter),
    .swap_forward_bit (swap_forward_bit),
    .pwm_set          (pwm_set),
    .led_data         (led_data),
    .led_words        (led_words),
    .error            (error),
    .error_code       (error_code),
    .state            (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One strobe: inputs set at a negedge, captured at the next posedge,
  // outputs sampled at the following negedge, then one idle cycle.
  task automatic send_bit(input logic d, input logic p);
    in_data = d; parity_error = p; in_clk = 1'b1;
    @(negedge clk);
    last_swap = swap_forward_bit;
    last_pwm  = pwm_set;
    in_clk = 1'b0; parity_error = 1'b0;
    @(negedge clk);
  endtask

  // Sends a word first bit = MSB; mask bit 7 corresponds to the marker bit.
  task automatic send_byte(input logic [7:0] v, input int par_pos);
    swap_mask = '0; pwm_mask = '0;
    for (int i = 0; i < 8; i++) begin
      send_bit(v[7-i], i == par_pos);
      swap_mask[7-i] = last_swap;
      pwm_mask[7-i]  = last_pwm;
    end
  endtask

  task automatic gap();
    in_sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_sync = 1'b0; in_clk = 1'b0; in_data = 1'b0;
    parity_error = 1'b0; num_words = 3'd1;
    last_swap = 1'b0; last_pwm = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_bc", bit_counter, 0);
    check("rst_led", led_data, 0);
    check("rst_words", led_words, 0);
    check("rst_err", {error, error_code, pwm_set, swap_forward_bit}, 0);

    // Single word: 0x00 skipped, 0xA5 claimed, 0x81 overruns.
    in_sync = 1'b1; num_words = 3'd1;
    send_byte(8'h00, -1);
    check("t1_skip_swap", swap_mask, 8'h00);
    check("t1_skip_state", state, 0);
    send_byte(8'hA5, -1);
    check("t1_swap", swap_mask, 8'h80);
    check("t1_pwm", pwm_mask, 8'h01);
    check("t1_led", led_data, 32'h0000_00A5);
    check("t1_words", led_words, 1);
    check("t1_state", state, 2);
    check("t1_noerr", error, 0);
    send_byte(8'h81, -1);
    check("t1_done_swap", swap_mask, 8'h00);
    check("t1_ovr", {error, error_code}, {1'b1, 2'd2});
    gap();
    check("gap_state", state, 0);
    check("gap_err", {error, error_code}, 0);
    check("gap_led", led_data, 32'h0000_00A5);

    // Three words.
    in_sync = 1'b1; num_words = 3'd3;
    send_byte(8'h81, -1);
    check("t2_w0_swap", swap_mask, 8'h80);
    check("t2_w0_pwm", pwm_mask, 8'h00);
    send_byte(8'h92, -1);
    check("t2_w1_swap", swap_mask, 8'h80);
    check("t2_w1_pwm", pwm_mask, 8'h00);
    send_byte(8'hA3, -1);
    check("t2_w2_swap", swap_mask, 8'h80);
    check("t2_w2_pwm", pwm_mask, 8'h01);
    check("t2_led", led_data, 32'h00A3_9281);
    check("t2_words", led_words, 3);
    check("t2_err", {error, error_code}, 0);
    gap();

    // Missing continuation marker on word 1.
    in_sync = 1'b1; num_words = 3'd2;
    send_byte(8'hC3, -1);
    send_byte(8'h12, -1);
    check("t3_swap", swap_mask, 8'h80);
    check("t3_pwm", pwm_mask, 8'h01);
    check("t3_err", {error, error_code}, {1'b1, 2'd1});
    check("t3_led", led_data, 32'h0000_12C3);
    check("t3_words", led_words, 2);
    gap();

    // Parity abort on bit 5 of the claimed word.
    in_sync = 1'b1; num_words = 3'd1;
    send_byte(8'hF0, 5);
    check("t4_pwm", pwm_mask, 8'h00);
    check("t4_state", state, 2);
    check("t4_err", {error, error_code}, {1'b1, 2'd3});
    check("t4_led", led_data, 32'h0000_12C3);
    check("t4_words", led_words, 2);
    send_bit(1'b1, 1'b0);
    check("t4_first_err_kept", error_code, 3);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t4_bc", bit_counter, 3);
    gap();

    // in_sync drop mid-capture, then a fresh frame.
    in_sync = 1'b1; num_words = 3'd1;
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    check("t5_cap", state, 1);
    gap();
    check("t5_state", state, 0);
    check("t5_bc", bit_counter, 0);
    check("t5_led_kept", led_data, 32'h0000_12C3);
    in_sync = 1'b1;
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t5_led_pending", led_data, 32'h0000_12C3);
    send_bit(1'b1, 1'b0);
    check("t5_pwm", last_pwm, 1);
    check("t5_led", led_data, 32'h0000_00B7);
    check("t5_words", led_words, 1);
    gap();

    // num_words = 0 behaves as 1.
    in_sync = 1'b1; num_words = 3'd0;
    send_byte(8'h8C, -1);
    check("t6_zero_led", led_data, 32'h0000_008C);
    check("t6_zero_words", led_words, 1);
    check("t6_zero_state", state, 2);
    gap();

    // num_words = 7 clamps to 4; a fifth marked word is an overrun.
    in_sync = 1'b1; num_words = 3'd7;
    send_byte(8'h81, -1);
    send_byte(8'h82, -1);
    send_byte(8'h83, -1);
    send_byte(8'h84, -1);
    check("t6_max_pwm", pwm_mask, 8'h01);
    check("t6_max_led", led_data, 32'h8483_8281);
    check("t6_max_words", led_words, 4);
    send_byte(8'h85, -1);
    check("t6_max_ovr", {error, error_code}, {1'b1, 2'd2});
    gap();

    // Reset mid-frame.
    in_sync = 1'b1; num_words = 3'd2;
    send_byte(8'h8F, -1);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    check("t7_pre_bc", bit_counter, 3);
    check("t7_pre_state", state, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t7_state", state, 0);
    check("t7_bc", bit_counter, 0);
    check("t7_led", led_data, 0);
    check("t7_words", led_words, 0);
    check("t7_flags", {error, error_code, pwm_set, swap_forward_bit}, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
